// File: rtl/issue_queue_param.sv
// In-order multi-issue queue between decode and execute: circular buffer with intra-group hazard checks.
// Latency: an entry enqueued at edge N reaches iss_* after edge N+1 at the earliest.
// Backpressure: enq_ready drops unless the whole group fits; stall freezes issue; flush discards all.
module issue_queue_param #(
    parameter int DEPTH  = 8,
    parameter int ENQ_W  = 2,
    parameter int ISS_W  = 2,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [ENQ_W-1:0]           enq_valid,
    input  logic [ENQ_W*DATA_W-1:0]    enq_data,
    input  logic [ENQ_W*5-1:0]         enq_dst,
    input  logic [ENQ_W*5-1:0]         enq_srca,
    input  logic [ENQ_W*5-1:0]         enq_srcb,
    input  logic [ENQ_W-1:0]           enq_wr,
    input  logic [ENQ_W-1:0]           enq_mem,
    input  logic [ENQ_W-1:0]           enq_bj,
    input  logic [ENQ_W-1:0]           enq_serial,
    output logic                       enq_ready,
    input  logic                       stall,
    input  logic                       flush,
    output logic [ISS_W-1:0]           iss_valid,
    output logic [ISS_W*DATA_W-1:0]    iss_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = PW + 3;

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic [4:0]        dst;
        logic [4:0]        srca;
        logic [4:0]        srcb;
        logic              wr;
        logic              mem;
        logic              bj;
        logic              serial;
    } entry_t;

    entry_t          q [DEPTH];
    logic [PW-1:0]   head, tail;
    logic [SW-1:0]   cnt_w, enq_n, deq_n, count_nxt;
    logic            enq_fire;
    logic [ISS_W-1:0] mask;
    entry_t          cand [ISS_W];
    entry_t          lane_in [ENQ_W];
    logic [PW-1:0]   enq_off [ENQ_W];

    assign cnt_w = SW'(count);

    // Valid lanes are compacted: each lane's slot offset is the number of valid lanes below it.
    always_comb begin
        enq_n = '0;
        for (int i = 0; i < ENQ_W; i++) begin
            enq_off[i]        = enq_n[PW-1:0];
            lane_in[i].dat    = enq_data[i*DATA_W +: DATA_W];
            lane_in[i].dst    = enq_dst[i*5 +: 5];
            lane_in[i].srca   = enq_srca[i*5 +: 5];
            lane_in[i].srcb   = enq_srcb[i*5 +: 5];
            lane_in[i].wr     = enq_wr[i];
            lane_in[i].mem    = enq_mem[i];
            lane_in[i].bj     = enq_bj[i];
            lane_in[i].serial = enq_serial[i];
            enq_n             = enq_n + SW'(enq_valid[i]);
        end
    end

    assign enq_ready = (cnt_w + enq_n) <= SW'(DEPTH);
    assign enq_fire  = enq_ready && !flush;

    always_comb begin
        logic prev_ok, ser_seen, mem_seen, raw;
        mask     = '0;
        deq_n    = '0;
        prev_ok  = 1'b1;
        ser_seen = 1'b0;
        mem_seen = 1'b0;
        for (int k = 0; k < ISS_W; k++) begin
            cand[k] = q[head + PW'(k)];
            raw     = 1'b0;
            for (int j = 0; j < k; j++)
                if (cand[j].wr && cand[j].dst != 5'd0 &&
                    (cand[j].dst == cand[k].srca || cand[j].dst == cand[k].srcb))
                    raw = 1'b1;
            if (k == 0)
                // A branch holds until its delay slot is also in the queue.
                mask[k] = (cnt_w > SW'(0)) && !(cand[k].bj && cnt_w < SW'(2));
            else
                mask[k] = prev_ok && (cnt_w > SW'(k)) && !cand[k].bj && !cand[k].serial &&
                          !ser_seen && !raw && !(cand[k].mem && mem_seen);
            prev_ok  = mask[k];
            ser_seen = ser_seen | cand[k].serial;
            mem_seen = mem_seen | cand[k].mem;
            deq_n    = deq_n + SW'(mask[k]);
        end
    end

    assign count_nxt = cnt_w + (enq_fire ? enq_n : '0) - (stall ? '0 : deq_n);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            iss_valid <= '0;
            iss_data  <= '0;
            for (int i = 0; i < DEPTH; i++)
                q[i] <= '0;
        end else if (flush) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            iss_valid <= '0;
            iss_data  <= '0;
        end else begin
            if (!stall) begin
                iss_valid <= mask;
                for (int k = 0; k < ISS_W; k++) begin
                    iss_data[k*DATA_W +: DATA_W] <= mask[k] ? cand[k].dat : '0;
                    if (mask[k])
                        q[head + PW'(k)] <= '0;
                end
                head <= head + deq_n[PW-1:0];
            end
            // Enqueue slots are always free, so they never collide with the entries freed above.
            if (enq_fire) begin
                for (int i = 0; i < ENQ_W; i++)
                    if (enq_valid[i])
                        q[tail + enq_off[i]] <= lane_in[i];
                tail <= tail + enq_n[PW-1:0];
            end
            count <= count_nxt[PW:0];
        end
    end
endmodule

// File: tb/tb_issue_queue_param.sv
// Bench for issue_queue_param: directed vector table plus randomized traffic against a queue-based model.
module tb_issue_queue_param;
    localparam int DEPTH = 8, ENQ_W = 2, ISS_W = 2, DATA_W = 64;

    typedef struct packed {
        logic       wr, mem, bj, ser;
        logic [4:0] dst, sa, sb;
    } op_t;

    typedef struct packed {
        logic [63:0] d;
        op_t         op;
    } ment_t;

    typedef struct {
        logic [1:0] ev;
        op_t        o0, o1;
        logic       st, fl, rdy;
        logic [1:0] iv;
        int         cnt;
    } vec_t;

    logic                    clk, resetn;
    logic [ENQ_W-1:0]        enq_valid;
    logic [ENQ_W*DATA_W-1:0] enq_data;
    logic [ENQ_W*5-1:0]      enq_dst, enq_srca, enq_srcb;
    logic [ENQ_W-1:0]        enq_wr, enq_mem, enq_bj, enq_serial;
    logic                    enq_ready, stall, flush;
    logic [ISS_W-1:0]        iss_valid;
    logic [ISS_W*DATA_W-1:0] iss_data;
    logic [$clog2(DEPTH):0]  count;

    issue_queue_param #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .ISS_W(ISS_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .resetn(resetn), .enq_valid(enq_valid), .enq_data(enq_data),
        .enq_dst(enq_dst), .enq_srca(enq_srca), .enq_srcb(enq_srcb), .enq_wr(enq_wr),
        .enq_mem(enq_mem), .enq_bj(enq_bj), .enq_serial(enq_serial), .enq_ready(enq_ready),
        .stall(stall), .flush(flush), .iss_valid(iss_valid), .iss_data(iss_data), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_chk, n_fail;
    ment_t  mq[$];
    logic   m_rdy;
    logic [1:0]   m_iv;
    logic [127:0] m_id;
    op_t    lane_op [2];
    vec_t   vt[$];

    function automatic op_t alu(int d, int a, int b);
        return '{wr: 1'b1, mem: 1'b0, bj: 1'b0, ser: 1'b0, dst: 5'(d), sa: 5'(a), sb: 5'(b)};
    endfunction
    function automatic op_t ld(int d, int a, int b);
        return '{wr: 1'b1, mem: 1'b1, bj: 1'b0, ser: 1'b0, dst: 5'(d), sa: 5'(a), sb: 5'(b)};
    endfunction
    function automatic op_t br(int a, int b);
        return '{wr: 1'b0, mem: 1'b0, bj: 1'b1, ser: 1'b0, dst: 5'd0, sa: 5'(a), sb: 5'(b)};
    endfunction
    function automatic op_t ser();
        return '{wr: 1'b0, mem: 1'b0, bj: 1'b0, ser: 1'b1, dst: 5'd0, sa: 5'd0, sb: 5'd0};
    endfunction
    function automatic op_t rnd_op();
        op_t o;
        o.wr  = 1'($urandom_range(0, 1));
        o.mem = ($urandom_range(0, 3) == 0);
        o.bj  = ($urandom_range(0, 7) == 0);
        o.ser = ($urandom_range(0, 15) == 0);
        o.dst = 5'($urandom_range(0, 3));
        o.sa  = 5'($urandom_range(0, 3));
        o.sb  = 5'($urandom_range(0, 3));
        return o;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ev, input op_t o0, input op_t o1, input logic st, input logic fl);
        lane_op[0] = o0;
        lane_op[1] = o1;
        enq_valid  = ev;
        enq_data   = {$urandom, $urandom, $urandom, $urandom};
        enq_wr     = {o1.wr, o0.wr};
        enq_mem    = {o1.mem, o0.mem};
        enq_bj     = {o1.bj, o0.bj};
        enq_serial = {o1.ser, o0.ser};
        enq_dst    = {o1.dst, o0.dst};
        enq_srca   = {o1.sa, o0.sa};
        enq_srcb   = {o1.sb, o0.sb};
        stall      = st;
        flush      = fl;
    endtask

    // Reference: a FIFO of instructions; the issue group is the longest legal prefix.
    task automatic model_step();
        int  n, ni;
        bit  blk, ser_g, mem_g, raw;
        ment_t e;
        n     = int'(enq_valid[0]) + int'(enq_valid[1]);
        m_rdy = (mq.size() + n) <= DEPTH;
        if (flush) begin
            mq.delete();
            m_iv = '0;
            m_id = '0;
        end else begin
            ni = 0; blk = 0; ser_g = 0; mem_g = 0;
            if (!stall) begin
                for (int k = 0; k < ISS_W; k++) begin
                    if (k < mq.size() && !blk) begin
                        e   = mq[k];
                        raw = 0;
                        for (int j = 0; j < k; j++)
                            if (mq[j].op.wr && mq[j].op.dst != 0 &&
                                (mq[j].op.dst == e.op.sa || mq[j].op.dst == e.op.sb))
                                raw = 1;
                        if (e.op.bj && (k > 0 || mq.size() < 2)) blk = 1;
                        if (k > 0 && (e.op.ser || ser_g || raw || (e.op.mem && mem_g))) blk = 1;
                        if (!blk) begin
                            ni++;
                            ser_g |= e.op.ser;
                            mem_g |= e.op.mem;
                        end
                    end
                end
                m_iv = '0;
                m_id = '0;
                for (int k = 0; k < ni; k++) begin
                    m_iv[k]        = 1'b1;
                    m_id[k*64 +: 64] = mq[k].d;
                end
            end
            if (m_rdy)
                for (int i = 0; i < 2; i++)
                    if (enq_valid[i])
                        mq.push_back('{d: enq_data[i*64 +: 64], op: lane_op[i]});
            if (!stall)
                repeat (ni) void'(mq.pop_front());
        end
    endtask

    task automatic cycle(input bit tab, input logic t_rdy, input logic [1:0] t_iv, input int t_cnt);
        #1;
        model_step();
        chk("enq_ready", {127'd0, enq_ready}, {127'd0, m_rdy});
        if (tab) chk("tab_enq_ready", {127'd0, enq_ready}, {127'd0, t_rdy});
        @(posedge clk);
        @(negedge clk);
        chk("iss_valid", {126'd0, iss_valid}, {126'd0, m_iv});
        chk("iss_data", iss_data, m_id);
        chk("count", {124'd0, count}, 128'(mq.size()));
        if (tab) begin
            chk("tab_iss_valid", {126'd0, iss_valid}, {126'd0, t_iv});
            chk("tab_count", {124'd0, count}, 128'(t_cnt));
        end
    endtask

    task automatic add(input logic [1:0] ev, input op_t o0, input op_t o1, input logic st, input logic fl,
                       input logic rdy, input logic [1:0] iv, input int cnt);
        vt.push_back('{ev, o0, o1, st, fl, rdy, iv, cnt});
    endtask

    initial begin
        op_t a, z;
        n_chk = 0;
        n_fail = 0;
        a = alu(1, 0, 0);
        z = '0;
        // ev, lane0, lane1, stall, flush, exp_ready, exp_iss_valid, exp_count
        add(2'b11, alu(1, 2, 3), alu(4, 6, 7), 0, 0, 1, 2'b00, 2);
        add(2'b00, z, z, 0, 0, 1, 2'b11, 0);
        add(2'b00, z, z, 0, 0, 1, 2'b00, 0);
        add(2'b11, alu(5, 1, 2), alu(8, 5, 3), 0, 0, 1, 2'b00, 2);
        add(2'b00, z, z, 0, 0, 1, 2'b01, 1);
        add(2'b00, z, z, 0, 0, 1, 2'b01, 0);
        add(2'b11, alu(0, 1, 2), alu(8, 0, 3), 0, 0, 1, 2'b00, 2);
        add(2'b00, z, z, 0, 0, 1, 2'b11, 0);
        add(2'b01, br(1, 2), z, 0, 0, 1, 2'b00, 1);
        add(2'b00, z, z, 0, 0, 1, 2'b00, 1);
        add(2'b01, alu(9, 1, 2), z, 0, 0, 1, 2'b00, 2);
        add(2'b00, z, z, 0, 0, 1, 2'b11, 0);
        add(2'b11, ld(10, 1, 2), ld(11, 3, 4), 0, 0, 1, 2'b00, 2);
        add(2'b00, z, z, 0, 0, 1, 2'b01, 1);
        add(2'b00, z, z, 0, 0, 1, 2'b01, 0);
        add(2'b11, alu(1, 2, 3), ser(), 0, 0, 1, 2'b00, 2);
        add(2'b11, alu(12, 2, 3), alu(13, 2, 3), 0, 0, 1, 2'b01, 3);
        add(2'b00, z, z, 0, 0, 1, 2'b01, 2);
        add(2'b00, z, z, 0, 0, 1, 2'b11, 0);
        add(2'b11, a, a, 1, 0, 1, 2'b11, 2);
        add(2'b11, a, a, 1, 0, 1, 2'b11, 4);
        add(2'b11, a, a, 1, 0, 1, 2'b11, 6);
        add(2'b01, a, z, 1, 0, 1, 2'b11, 7);
        add(2'b11, a, a, 1, 0, 0, 2'b11, 7);
        add(2'b01, a, z, 1, 0, 1, 2'b11, 8);
        add(2'b00, z, z, 0, 0, 1, 2'b11, 6);
        add(2'b00, z, z, 0, 0, 1, 2'b11, 4);
        add(2'b00, z, z, 0, 0, 1, 2'b11, 2);
        add(2'b00, z, z, 0, 0, 1, 2'b11, 0);
        add(2'b00, z, z, 0, 0, 1, 2'b00, 0);
        add(2'b11, a, a, 0, 0, 1, 2'b00, 2);
        add(2'b11, a, a, 1, 1, 1, 2'b00, 0);
        add(2'b00, z, z, 0, 0, 1, 2'b00, 0);

        resetn = 1'b0;
        drive(2'b00, z, z, 0, 0);
        m_iv = '0;
        m_id = '0;
        repeat (2) @(negedge clk);
        chk("reset_count", {124'd0, count}, 128'd0);
        chk("reset_iss_valid", {126'd0, iss_valid}, 128'd0);
        chk("reset_iss_data", iss_data, 128'd0);
        chk("reset_enq_ready", {127'd0, enq_ready}, 128'd1);
        resetn = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i].ev, vt[i].o0, vt[i].o1, vt[i].st, vt[i].fl);
            cycle(1'b1, vt[i].rdy, vt[i].iv, vt[i].cnt);
        end

        // Asynchronous reset while entries are still draining.
        drive(2'b11, a, a, 0, 0); cycle(1'b0, 1'b0, 2'b00, 0);
        drive(2'b11, a, a, 1, 0); cycle(1'b0, 1'b0, 2'b00, 0);
        drive(2'b00, z, z, 0, 0); cycle(1'b0, 1'b0, 2'b00, 0);
        resetn = 1'b0;
        #1;
        chk("async_reset_count", {124'd0, count}, 128'd0);
        chk("async_reset_iss_valid", {126'd0, iss_valid}, 128'd0);
        chk("async_reset_iss_data", iss_data, 128'd0);
        mq.delete();
        m_iv = '0;
        m_id = '0;
        @(negedge clk);
        resetn = 1'b1;

        for (int c = 0; c < 600; c++) begin
            drive(2'($urandom_range(0, 3)), rnd_op(), rnd_op(),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0));
            cycle(1'b0, 1'b0, 2'b00, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
